// File: rtl/bit_morph_pkg.sv
// Shared definitions for the bit_morph_filter binary morphology stage.
package bit_morph_pkg;

    typedef enum logic {
        MODE_DILATE = 1'b0,
        MODE_ERODE  = 1'b1
    } morph_mode_e;

    // Clocks from input sync signals to output sync signals.
    localparam int unsigned SYNC_LAT = 3;

    // Ceiling log2 with a floor of 1, used for counter and address widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bit_morph_filter_line_buffer.sv
// bit_line_buffer: KSIZE-1 cascaded 1-bit line stores of IMG_HDISP pixels.
// Tap k returns the pixel at the current column from k+1 lines ago; the
// matching valid flag says whether that line belongs to the current frame.
module bit_line_buffer
    import bit_morph_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter int unsigned KSIZE     = 3,
    parameter int unsigned AW        = clog2(32'(IMG_HDISP))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_bit,
    input  logic              i_line_done,
    input  logic              i_frame_start,
    output logic [KSIZE-2:0]  o_taps,
    output logic [KSIZE-2:0]  o_valid
);

    logic r_mem [KSIZE-1][IMG_HDISP];
    logic [KSIZE-2:0] r_valid;

    // Write the new pixel into line 0 and push each older line one row down.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[0][i_addr] <= i_bit;
            for (int unsigned k = 1; k < KSIZE - 1; k++) begin
                r_mem[k][i_addr] <= r_mem[k-1][i_addr];
            end
        end
    end

    // Track how many complete lines of the current frame are held; frame start wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_frame_start) begin
            r_valid <= '0;
        end else if (i_line_done) begin
            r_valid[0] <= 1'b1;
            for (int unsigned k = 1; k < KSIZE - 1; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Read taps at the current column before this cycle's write lands.
    always_comb begin
        o_taps = '0;
        for (int unsigned k = 0; k < KSIZE - 1; k++) begin
            o_taps[k] = r_mem[k][i_addr];
        end
        o_valid = r_valid;
    end

endmodule

// File: rtl/bit_morph_filter.sv
// bit_morph_filter: KSIZE x KSIZE binary dilation/erosion with neutral padding.
// Output image is shifted by R=(KSIZE-1)/2 rows and columns; latency 3 clk.
// Optional build macro BIT_MORPH_STATS_EN adds per-frame foreground counting.
module bit_morph_filter
    import bit_morph_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter int unsigned KSIZE     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_mode,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_bit,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_bit
`ifdef BIT_MORPH_STATS_EN
    ,
    output logic [21:0] fg_count,
    output logic        fg_count_valid
`endif
);

    localparam int unsigned R   = (KSIZE - 1) / 2;
    localparam int unsigned AW  = clog2(32'(IMG_HDISP));
    localparam logic [10:0] R_L = 11'(R);

    if (!(KSIZE == 3 || KSIZE == 5)) begin : g_ksize_bad
        $error("bit_morph_filter: KSIZE must be 3 or 5");
    end

    morph_mode_e       r_mode;
    logic              r_vsync_d;
    logic              r_href_d;
    logic [10:0]       r_col_cnt;
    logic [10:0]       r_row_cnt;
    logic              w_vsync_rise;
    logic              w_href_fall;
    logic              w_pix_en;
    logic              w_pad;
    logic [KSIZE-2:0]  w_taps;
    logic [KSIZE-2:0]  w_valid;
    logic [KSIZE-1:0]  w_newcol;
    logic [KSIZE-1:0]  r_win [KSIZE];
    logic              r_ok1;
    logic              r_ok2;
    morph_mode_e       r_mode1;
    morph_mode_e       r_mode2;
    logic [KSIZE-1:0]  r_rowred;
    logic [2:0]        r_sync [SYNC_LAT-1];

    assign w_vsync_rise = per_frame_vsync & ~r_vsync_d;
    assign w_href_fall  = ~per_frame_href & r_href_d;
    assign w_pix_en     = per_frame_href & per_frame_clken &
                          (r_col_cnt < IMG_HDISP) & (r_row_cnt < IMG_VDISP);
    assign w_pad        = (r_mode == MODE_ERODE);

    // Edge detection, per-frame mode latch and pixel/line counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
            r_mode    <= MODE_DILATE;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            r_vsync_d <= per_frame_vsync;
            r_href_d  <= per_frame_href;
            if (w_vsync_rise) begin
                r_mode <= morph_mode_e'(cfg_mode);
            end
            if (w_vsync_rise || w_href_fall) begin
                r_col_cnt <= '0;
            end else if (per_frame_href && per_frame_clken && r_col_cnt < IMG_HDISP) begin
                r_col_cnt <= r_col_cnt + 11'd1;
            end
            if (w_vsync_rise) begin
                r_row_cnt <= '0;
            end else if (w_href_fall && r_row_cnt < IMG_VDISP) begin
                r_row_cnt <= r_row_cnt + 11'd1;
            end
        end
    end

    bit_line_buffer #(
        .IMG_HDISP (IMG_HDISP),
        .KSIZE     (KSIZE),
        .AW        (AW)
    ) u_line_buffer (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (w_pix_en),
        .i_addr        (r_col_cnt[AW-1:0]),
        .i_bit         (per_img_bit),
        .i_line_done   (w_href_fall && r_col_cnt >= IMG_HDISP),
        .i_frame_start (w_vsync_rise),
        .o_taps        (w_taps),
        .o_valid       (w_valid)
    );

    // Incoming window column, bottom row is the live pixel; stale lines become pad.
    always_comb begin
        w_newcol = '0;
        w_newcol[KSIZE-1] = per_img_bit;
        for (int unsigned k = 0; k < KSIZE - 1; k++) begin
            w_newcol[KSIZE-2-k] = w_valid[k] ? w_taps[k] : w_pad;
        end
    end

    // Stage 1: shift the window; at column 0 the older columns are left of the
    // image, so they are refilled with pad instead of keeping last line's pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < KSIZE; j++) begin
                r_win[j] <= '0;
            end
            r_ok1   <= 1'b0;
            r_mode1 <= MODE_DILATE;
        end else begin
            if (w_pix_en) begin
                for (int unsigned j = 0; j < KSIZE; j++) begin
                    if (r_col_cnt == '0) begin
                        r_win[j] <= {w_newcol[j], {(KSIZE-1){w_pad}}};
                    end else begin
                        r_win[j] <= {w_newcol[j], r_win[j][KSIZE-1:1]};
                    end
                end
            end
            r_ok1   <= w_pix_en && (r_col_cnt >= R_L) && (r_row_cnt >= R_L);
            r_mode1 <= r_mode;
        end
    end

    // Stage 2: reduce each window row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rowred <= '0;
            r_ok2    <= 1'b0;
            r_mode2  <= MODE_DILATE;
        end else begin
            for (int unsigned j = 0; j < KSIZE; j++) begin
                r_rowred[j] <= (r_mode1 == MODE_ERODE) ? (&r_win[j]) : (|r_win[j]);
            end
            r_ok2   <= r_ok1;
            r_mode2 <= r_mode1;
        end
    end

    // Stage 3: combine row results into the output pixel, zero when not emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_img_bit <= 1'b0;
        end else begin
            post_img_bit <= r_ok2 &
                ((r_mode2 == MODE_ERODE) ? (&r_rowred) : (|r_rowred));
        end
    end

    // Sync signal delay line matching the three data stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_LAT - 1; i++) begin
                r_sync[i] <= '0;
            end
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
        end else begin
            r_sync[0] <= {per_frame_vsync, per_frame_href, per_frame_clken};
            for (int unsigned i = 1; i < SYNC_LAT - 1; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            {post_frame_vsync, post_frame_href, post_frame_clken} <= r_sync[SYNC_LAT-2];
        end
    end

`ifdef BIT_MORPH_STATS_EN
    logic [21:0] r_acc;
    logic        r_post_vsync_d;

    // Count emitted foreground pixels; publish and restart on output vsync falling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc          <= '0;
            r_post_vsync_d <= 1'b0;
            fg_count       <= '0;
            fg_count_valid <= 1'b0;
        end else begin
            r_post_vsync_d <= post_frame_vsync;
            if (!post_frame_vsync && r_post_vsync_d) begin
                fg_count       <= r_acc;
                fg_count_valid <= 1'b1;
                r_acc          <= '0;
            end else begin
                fg_count_valid <= 1'b0;
                if (post_img_bit && post_frame_clken) begin
                    r_acc <= r_acc + 22'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bit_morph_filter.sv
// Self-checking bench for bit_morph_filter (KSIZE 3 on 8x6, KSIZE 5 on 10x8).
module tb_bit_morph_filter;

    logic clk = 1'b0;
    logic rst;
    logic cfg_mode;
    logic vsync, href, clken, pbit;
    logic pv3, ph3, pc3, pb3;
    logic pv5, ph5, pc5, pb5;
`ifdef BIT_MORPH_STATS_EN
    logic [21:0] fg3, fg5;
    logic        fgv3, fgv5;
    int          pulses = 0;
    int          last_fg = 0;
`endif

    always #5 clk = ~clk;

    bit_morph_filter #(.IMG_HDISP(11'd8), .IMG_VDISP(11'd6), .KSIZE(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_bit(pbit),
        .post_frame_vsync(pv3), .post_frame_href(ph3), .post_frame_clken(pc3),
        .post_img_bit(pb3)
`ifdef BIT_MORPH_STATS_EN
        , .fg_count(fg3), .fg_count_valid(fgv3)
`endif
    );

    bit_morph_filter #(.IMG_HDISP(11'd10), .IMG_VDISP(11'd8), .KSIZE(5)) dut5 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_bit(pbit),
        .post_frame_vsync(pv5), .post_frame_href(ph5), .post_frame_clken(pc5),
        .post_img_bit(pb5)
`ifdef BIT_MORPH_STATS_EN
        , .fg_count(fg5), .fg_count_valid(fgv5)
`endif
    );

    int  total = 0;
    int  bad   = 0;
    bit  img [0:9][0:9];
    bit  q3[$];
    bit  q5[$];
    bit  saved[$];
    bit  chk_sync = 1'b0;
    logic [2:0] hv0 = '0, hv1 = '0, hv2 = '0;

    typedef struct {
        string name;
        bit    k5;
        bit    mode;
        int    pat;
        int    gap;
        int    exp_ones;
        int    px;
        int    py;
        bit    pv;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Input history for the sync-latency check.
    always @(posedge clk) begin
        hv2 = hv1;
        hv1 = hv0;
        hv0 = {vsync, href, clken};
    end

    // Collect emitted pixels and watch the blanking rule.
    always @(negedge clk) begin
        if (pc3 && ph3) q3.push_back(pb3);
        if (pc5 && ph5) q5.push_back(pb5);
        if (!ph3) check("bit3_zero_outside_href", pb3, 0);
        if (!ph5) check("bit5_zero_outside_href", pb5, 0);
        if (chk_sync) check("sync_delay3", {pv3, ph3, pc3}, hv2);
`ifdef BIT_MORPH_STATS_EN
        if (fgv3) begin
            pulses++;
            last_fg = fg3;
        end
`endif
    end

    // Reference: reduce the KxK neighbourhood centred R left/up of (x,y).
    function automatic bit model(input int x, input int y, input int W, input int H,
                                 input int K, input bit mode);
        int r;
        bit acc;
        r = (K - 1) / 2;
        acc = mode;
        if (x < r || y < r) return 1'b0;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                int px, py;
                bit p;
                px = x - r + dx;
                py = y - r + dy;
                p = (px < 0 || py < 0 || px >= W || py >= H) ? mode : img[py][px];
                acc = mode ? (acc & p) : (acc | p);
            end
        end
        return acc;
    endfunction

    task automatic set_block(input int cx, input int cy, input int half);
        for (int y = cy - half; y <= cy + half; y++)
            for (int x = cx - half; x <= cx + half; x++)
                img[y][x] = 1'b1;
    endtask

    task automatic set_pattern(input int pat, input bit mode);
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                img[y][x] = (pat == 1) ? 1'b1 :
                            (pat == 4) ? (mode ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0)) :
                            1'b0;
        if (pat == 0) img[3][4] = 1'b1;
        if (pat == 2) set_block(4, 4, 1);
        if (pat == 3) set_block(4, 4, 2);
        if (pat == 5) set_block(3, 2, 1);
    endtask

    task automatic drive_frame(input int W, input int H, input bit mode, input int gap_pct,
                               input int sw_row, input bit sw_val);
        cfg_mode = mode;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int y = 0; y < H; y++) begin
            if (y == sw_row) cfg_mode = sw_val;
            href = 1'b1;
            for (int x = 0; x < W; x++) begin
                int g;
                g = 0;
                while (g < 8 && $urandom_range(99) < gap_pct) begin
                    clken = 1'b0;
                    pbit = 1'($urandom_range(1));
                    @(negedge clk);
                    g++;
                end
                clken = 1'b1;
                pbit = img[y][x];
                @(negedge clk);
            end
            href = 1'b0;
            clken = 1'b0;
            pbit = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_stream(input string name, input bit k5, input int W, input int H,
                                input bit mode, input int exp_ones, input int px,
                                input int py, input bit pv);
        bit got[$];
        int ones;
        int k;
        if (k5) got = q5; else got = q3;
        check({name, "_len"}, got.size(), W * H);
        if (got.size() != W * H) return;
        ones = 0;
        k = k5 ? 5 : 3;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                bit e;
                e = model(x, y, W, H, k, mode);
                total++;
                if (got[y*W+x] != e) begin
                    bad++;
                    $display("FAIL %s pix(%0d,%0d): got %0d expected %0d", name, x, y, got[y*W+x], e);
                end
                ones += int'(got[y*W+x]);
            end
        end
        if (exp_ones >= 0) check({name, "_ones"}, ones, exp_ones);
        if (px >= 0) check({name, "_probe"}, int'(got[py*W+px]), int'(pv));
    endtask

    initial begin
        vec_t tbl [8];
        int   W, H, diffs;

        rst = 1'b1; cfg_mode = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; pbit = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_post_href3",  ph3, 0);
        check("reset_post_vsync3", pv3, 0);
        check("reset_post_clken3", pc3, 0);
        check("reset_post_bit3",   pb3, 0);
        check("reset_post_bit5",   pb5, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        tbl[0] = '{"k3_dil_single",   1'b0, 1'b0, 0, 0,  9,  5,  4, 1'b1};
        tbl[1] = '{"k3_ero_ones",     1'b0, 1'b1, 1, 0,  35, 1,  1, 1'b1};
        tbl[2] = '{"k3_ero_ones_gap", 1'b0, 1'b1, 1, 30, 35, 0,  3, 1'b0};
        tbl[3] = '{"k5_ero_3x3",      1'b1, 1'b1, 2, 0,  0,  -1, -1, 1'b0};
        tbl[4] = '{"k5_ero_5x5",      1'b1, 1'b1, 3, 0,  1,  6,  6, 1'b1};
        tbl[5] = '{"k5_dil_rand",     1'b1, 1'b0, 4, 20, -1, -1, -1, 1'b0};
        tbl[6] = '{"k3_ero_rand_gap", 1'b0, 1'b1, 4, 50, -1, -1, -1, 1'b0};
        tbl[7] = '{"k5_ero_rand",     1'b1, 1'b1, 4, 0,  -1, -1, -1, 1'b0};

        foreach (tbl[i]) begin
            W = tbl[i].k5 ? 10 : 8;
            H = tbl[i].k5 ? 8 : 6;
            set_pattern(tbl[i].pat, tbl[i].mode);
            q3.delete(); q5.delete();
            drive_frame(W, H, tbl[i].mode, tbl[i].gap, -1, 1'b0);
            check_stream(tbl[i].name, tbl[i].k5, W, H, tbl[i].mode,
                         tbl[i].exp_ones, tbl[i].px, tbl[i].py, tbl[i].pv);
        end

        // Mode change mid-frame: current frame stays dilated, next is eroded.
        set_pattern(5, 1'b0);
        q3.delete(); q5.delete();
        drive_frame(8, 6, 1'b0, 0, 3, 1'b1);
        check_stream("mode_switch_cur", 1'b0, 8, 6, 1'b0, 25, 2, 1, 1'b1);
        q3.delete(); q5.delete();
        drive_frame(8, 6, 1'b1, 0, -1, 1'b1);
        check_stream("mode_switch_next", 1'b0, 8, 6, 1'b1, 1, 4, 3, 1'b1);

        // Gapped run against gap-free run of the same image, with sync latency check.
        set_pattern(4, 1'b0);
        q3.delete(); q5.delete();
        chk_sync = 1'b1;
        drive_frame(8, 6, 1'b0, 50, -1, 1'b0);
        chk_sync = 1'b0;
        saved = q3;
        check_stream("gap_dil_rand", 1'b0, 8, 6, 1'b0, -1, -1, -1, 1'b0);
        q3.delete(); q5.delete();
        drive_frame(8, 6, 1'b0, 0, -1, 1'b0);
        check("gap_vs_nogap_len", q3.size(), saved.size());
        diffs = 0;
        for (int i = 0; i < q3.size() && i < saved.size(); i++)
            if (q3[i] != saved[i]) diffs++;
        check("gap_vs_nogap_diffs", diffs, 0);

        // Reset asserted in the middle of a line.
        set_pattern(1, 1'b0);
        cfg_mode = 1'b0;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        href = 1'b1;
        clken = 1'b1;
        pbit = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_href3", ph3, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_href3",  ph3, 0);
        check("async_rst_clken3", pc3, 0);
        check("async_rst_vsync3", pv3, 0);
        check("async_rst_bit3",   pb3, 0);
        check("async_rst_href5",  ph5, 0);
        @(negedge clk);
        href = 1'b0; clken = 1'b0; pbit = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        set_pattern(0, 1'b0);
        q3.delete(); q5.delete();
        drive_frame(8, 6, 1'b0, 0, -1, 1'b0);
        check_stream("after_reset_dil", 1'b0, 8, 6, 1'b0, 9, 5, 4, 1'b1);
`ifdef BIT_MORPH_STATS_EN
        pulses = 0;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (8) @(negedge clk);
        check("stats_pulses", pulses, 1);
        check("stats_fg_count", last_fg, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
